// File: rtl/v1_pulse_gen_if.sv
// v1_pulse_gen_if: pulse emulator control and sample bus.
// master drives start/amplitude/baseline; slave returns samples and status.
interface v1_pulse_gen_if #(
  parameter int SIZE_ADC_DATA = 14,
  parameter int AMP_W         = 13
);
  logic                            start;
  logic        [AMP_W-1:0]         amplitude;
  logic signed [SIZE_ADC_DATA-1:0] baseline;
  logic signed [SIZE_ADC_DATA-1:0] output_data;
  logic                            busy;
  logic                            done;
  logic        [15:0]              drop_cnt;

  modport master (
    output start, amplitude, baseline,
    input  output_data, busy, done, drop_cnt
  );

  modport slave (
    input  start, amplitude, baseline,
    output output_data, busy, done, drop_cnt
  );
endinterface

// File: rtl/v1_pulse_gen.sv
// v1_pulse_gen: detector-pulse emulator feeding the trapezoidal shaper.
// Ports: clk, reset (sync, active-low), bus (slave): start, amplitude,
// baseline in; output_data, busy, done, drop_cnt out.
module v1_pulse_gen #(
  parameter int SIZE_ADC_DATA = 14,
  parameter int AMP_W         = 13,
  parameter int RISE_SHIFT    = 0,
  parameter int DECAY_SHIFT   = 4,
  parameter int HOLDOFF       = 8,
  parameter int PILEUP_EN     = 1
) (
  input logic           clk,
  input logic           reset,
  v1_pulse_gen_if.slave bus
);

  localparam int RC_W = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int MW   = SIZE_ADC_DATA + 2;

  localparam logic [RC_W-1:0] RC_LAST =
    RC_W'((1 << RISE_SHIFT) - 1);
  localparam logic [HC_W-1:0] HC_LAST =
    HC_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  localparam logic signed [MW-1:0] OMAX =
    MW'((1 << (SIZE_ADC_DATA - 1)) - 1);
  localparam logic signed [MW-1:0] OMIN =
    MW'(-(1 << (SIZE_ADC_DATA - 1)));

  typedef enum logic [1:0] {
    S_IDLE,
    S_RISE,
    S_DECAY,
    S_HOLDOFF
  } state_t;

  state_t           state;
  logic [AMP_W-1:0] acc;
  logic [AMP_W-1:0] target;
  logic [AMP_W-1:0] step;
  logic [RC_W-1:0]  rise_cnt;
  logic [HC_W-1:0]  hold_cnt;

  logic [AMP_W:0]   sum_tgt;
  logic [AMP_W-1:0] new_tgt;
  logic [AMP_W-1:0] amp_sh;
  logic [AMP_W-1:0] new_step;
  logic [AMP_W:0]   acc_step;
  logic             rise_end;
  logic [AMP_W-1:0] dec_raw;
  logic [AMP_W-1:0] dec;
  logic             decay_end;
  logic             can_take;
  logic             accept;
  logic             drop;

  logic signed [MW-1:0]            mix;
  logic signed [SIZE_ADC_DATA-1:0] sat;

  // Pile-up adds on top of the current level, so the sum
  // carries one extra bit and clamps to full scale.
  assign sum_tgt = {1'b0, acc} + {1'b0, bus.amplitude};
  assign new_tgt = sum_tgt[AMP_W] ? '1 : sum_tgt[AMP_W-1:0];

  assign amp_sh   = bus.amplitude >> RISE_SHIFT;
  assign new_step = (amp_sh == '0) ? AMP_W'(1) : amp_sh;

  assign acc_step = {1'b0, acc} + {1'b0, step};
  assign rise_end = (rise_cnt == RC_LAST) ||
                    (acc_step >= {1'b0, target});

  // Minimum decrement of 1 keeps the tail from stalling.
  assign dec_raw   = acc >> DECAY_SHIFT;
  assign dec       = (dec_raw == '0) ? AMP_W'(1) : dec_raw;
  assign decay_end = (acc <= dec);

  assign can_take = (state == S_IDLE) ||
                    ((PILEUP_EN != 0) && (state == S_DECAY));
  assign accept   = bus.start && can_take;
  assign drop     = bus.start && !can_take;

  assign mix =
    $signed({{2{bus.baseline[SIZE_ADC_DATA-1]}}, bus.baseline}) +
    $signed({{(MW-AMP_W){1'b0}}, acc});

  always_comb begin
    sat = mix[SIZE_ADC_DATA-1:0];
    if (mix > OMAX) begin
      sat = OMAX[SIZE_ADC_DATA-1:0];
    end else if (mix < OMIN) begin
      sat = OMIN[SIZE_ADC_DATA-1:0];
    end
  end

  assign bus.busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_IDLE;
      acc             <= '0;
      target          <= '0;
      step            <= '0;
      rise_cnt        <= '0;
      hold_cnt        <= '0;
      bus.output_data <= '0;
      bus.done        <= 1'b0;
      bus.drop_cnt    <= '0;
    end else begin
      bus.output_data <= sat;
      bus.done        <= 1'b0;

      if (drop && (bus.drop_cnt != 16'hFFFF)) begin
        bus.drop_cnt <= bus.drop_cnt + 16'd1;
      end

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            target   <= new_tgt;
            step     <= new_step;
            rise_cnt <= '0;
            state    <= S_RISE;
          end
        end
        S_RISE: begin
          if (rise_end) begin
            acc   <= target;
            state <= S_DECAY;
          end else begin
            acc      <= acc_step[AMP_W-1:0];
            rise_cnt <= rise_cnt + RC_W'(1);
          end
        end
        S_DECAY: begin
          if (accept) begin
            target   <= new_tgt;
            step     <= new_step;
            rise_cnt <= '0;
            state    <= S_RISE;
          end else if (decay_end) begin
            acc      <= '0;
            bus.done <= 1'b1;
            hold_cnt <= '0;
            state    <= (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
          end else begin
            acc <= acc - dec;
          end
        end
        S_HOLDOFF: begin
          if (hold_cnt == HC_LAST) begin
            state <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v1_pulse_gen.sv
// tb_v1_pulse_gen: step and ramp emulators run in lock-step
// against a per-cycle behavioural model plus directed checks.
module tb_v1_pulse_gen;

  localparam int SW   = 14;
  localparam int AW   = 13;
  localparam int AMAX = (1 << AW) - 1;
  localparam int OHI  = (1 << (SW - 1)) - 1;
  localparam int OLO  = -(1 << (SW - 1));
  localparam int DSH  = 4;
  localparam int HOLD = 8;

  localparam int M_IDLE  = 0;
  localparam int M_RISE  = 1;
  localparam int M_DECAY = 2;
  localparam int M_HOLD  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  v1_pulse_gen_if #(.SIZE_ADC_DATA(SW), .AMP_W(AW)) bus0 ();
  v1_pulse_gen_if #(.SIZE_ADC_DATA(SW), .AMP_W(AW)) bus1 ();

  v1_pulse_gen #(.RISE_SHIFT(0)) u_step (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  v1_pulse_gen #(.RISE_SHIFT(2)) u_ramp (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  int rsh[2] = '{0, 2};
  int m_st[2], m_acc[2], m_tgt[2], m_stp[2];
  int m_left[2], m_hold[2], m_out[2], m_drop[2];
  int m_done[2];

  task automatic m_start(int k, int amp);
    m_tgt[k]  = (m_acc[k] + amp > AMAX) ? AMAX : m_acc[k] + amp;
    m_stp[k]  = ((amp >> rsh[k]) < 1) ? 1 : (amp >> rsh[k]);
    m_left[k] = 1 << rsh[k];
    m_st[k]   = M_RISE;
  endtask

  task automatic model_step(int k, bit rst, bit st, int amp, int bl);
    int o;
    int d;
    if (!rst) begin
      m_st[k] = M_IDLE; m_acc[k] = 0; m_tgt[k] = 0; m_stp[k] = 0;
      m_left[k] = 0; m_hold[k] = 0; m_out[k] = 0; m_drop[k] = 0;
      m_done[k] = 0;
      return;
    end
    o = bl + m_acc[k];
    if (o > OHI) o = OHI;
    if (o < OLO) o = OLO;
    m_out[k]  = o;
    m_done[k] = 0;
    if (st && (m_st[k] == M_RISE || m_st[k] == M_HOLD))
      m_drop[k] = (m_drop[k] < 65535) ? m_drop[k] + 1 : 65535;
    case (m_st[k])
      M_IDLE: if (st) m_start(k, amp);
      M_RISE: begin
        if (m_left[k] == 1 || m_acc[k] + m_stp[k] >= m_tgt[k]) begin
          m_acc[k] = m_tgt[k];
          m_st[k]  = M_DECAY;
        end else begin
          m_acc[k]  = m_acc[k] + m_stp[k];
          m_left[k] = m_left[k] - 1;
        end
      end
      M_DECAY: begin
        if (st) begin
          m_start(k, amp);
        end else begin
          d = m_acc[k] / (1 << DSH);
          if (d == 0) d = 1;
          if (m_acc[k] <= d) begin
            m_acc[k]  = 0;
            m_done[k] = 1;
            m_hold[k] = HOLD;
            m_st[k]   = M_HOLD;
          end else begin
            m_acc[k] = m_acc[k] - d;
          end
        end
      end
      default: begin
        m_hold[k] = m_hold[k] - 1;
        if (m_hold[k] == 0) m_st[k] = M_IDLE;
      end
    endcase
  endtask

  task automatic tick(bit rst, bit st, int amp, int bl);
    @(negedge clk);
    reset          = rst;
    bus0.start     = st;
    bus0.amplitude = AW'(amp);
    bus0.baseline  = SW'(bl);
    bus1.start     = st;
    bus1.amplitude = AW'(amp);
    bus1.baseline  = SW'(bl);
    @(posedge clk);
    model_step(0, rst, st, amp, bl);
    model_step(1, rst, st, amp, bl);
    #1;
    chk("out0", int'(bus0.output_data), m_out[0]);
    chk("busy0", int'(bus0.busy), int'(m_st[0] != M_IDLE));
    chk("done0", int'(bus0.done), m_done[0]);
    chk("drop0", int'(bus0.drop_cnt), m_drop[0]);
    chk("out1", int'(bus1.output_data), m_out[1]);
    chk("busy1", int'(bus1.busy), int'(m_st[1] != M_IDLE));
    chk("done1", int'(bus1.done), m_done[1]);
    chk("drop1", int'(bus1.drop_cnt), m_drop[1]);
  endtask

  task automatic wait_done0();
    int n = 0;
    while (bus0.done !== 1'b1 && n < 400) begin
      tick(1, 0, 0, 100);
      n++;
    end
    chk("done0_wait", int'(bus0.done), 1);
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (bus0.busy !== 1'b0 && n < 400) begin
      tick(1, 0, 0, 100);
      n++;
    end
    chk("idle0_wait", int'(bus0.busy), 0);
  endtask

  initial begin
    int n;
    int bl;
    bit st;
    bit rst;

    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 1000, 100);
      chk("rst_out", int'(bus0.output_data), 0);
      chk("rst_busy", int'(bus1.busy), 0);
    end

    tick(1, 1, 1000, 100);
    tick(1, 0, 0, 100);
    tick(1, 0, 0, 100);
    chk("step_e2", int'(bus0.output_data), 1100);
    chk("ramp_e2", int'(bus1.output_data), 350);
    tick(1, 0, 0, 100);
    chk("step_e3", int'(bus0.output_data), 1038);
    chk("ramp_e3", int'(bus1.output_data), 600);
    tick(1, 0, 0, 100);
    chk("step_e4", int'(bus0.output_data), 980);
    chk("ramp_e4", int'(bus1.output_data), 850);
    tick(1, 0, 0, 100);
    chk("ramp_e5", int'(bus1.output_data), 1100);

    wait_done0();
    n = 0;
    while (bus0.busy === 1'b1 && n < 50) begin
      tick(1, 0, 0, 100);
      n++;
    end
    chk("busy_fall", n, HOLD);

    tick(0, 0, 0, 100);
    tick(1, 1, 1000, 100);
    tick(1, 0, 0, 100);
    tick(1, 0, 0, 100);
    tick(1, 1, 8000, 100);
    chk("pile_e3", int'(bus0.output_data), 1038);
    tick(1, 0, 0, 100);
    tick(1, 0, 0, 100);
    chk("pile_clamp", int'(bus0.output_data), OHI);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 100);
    chk("pile_nowrap", int'(bus0.output_data > 0), 1);

    tick(0, 0, 0, 100);
    tick(1, 1, 1000, 100);
    wait_done0();
    tick(1, 1, 1000, 100);
    chk("drop_hold", int'(bus0.drop_cnt), 1);
    wait_idle0();
    tick(1, 1, 500, 100);
    tick(1, 1, 500, 100);
    chk("drop2", int'(bus0.drop_cnt), 2);
    wait_done0();
    wait_idle0();

    tick(1, 1, 1000, 100);
    n = 0;
    while (int'(bus0.output_data) > 600 || n < 3) begin
      if (n > 100) break;
      tick(1, 0, 0, 100);
      n++;
    end
    tick(0, 0, 0, 100);
    chk("mid_rst_out", int'(bus0.output_data), 0);
    chk("mid_rst_busy", int'(bus0.busy), 0);
    tick(1, 1, 1000, 100);
    tick(1, 0, 0, 100);
    tick(1, 0, 0, 100);
    chk("post_rst_e2", int'(bus0.output_data), 1100);

    bl = 100;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0)
        bl = int'($urandom_range(0, 16383)) - 8192;
      st  = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 999) != 0);
      tick(rst, st, int'($urandom_range(0, AMAX)), bl);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
